ps2_key_decoder: RTL

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder_if.sv | 30 +++
 rtl/ps2_key_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder_if.sv
// +----------------------------------------------------------------------------+
// | Module      : ps2_key_decoder_if                                           |
// | Description : Raw PS/2 wires in, decoded key event and error pulse out.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

interface ps2_key_decoder_if;
  logic        ps2_clk;
  logic        ps2_dat;
  logic [10:0] ps2_key;
  logic        err;

  // Keyboard/stimulus side drives the wire pair and observes the decoded result.
  modport master (
    output ps2_clk,
    output ps2_dat,
    input  ps2_key,
    input  err
  );

  modport slave (
    input  ps2_clk,
    input  ps2_dat,
    output ps2_key,
    output err
  );
endinterface

`default_nettype wire

// File: rtl/ps2_key_decoder.sv
// +----------------------------------------------------------------------------+
// | Module      : ps2_key_decoder                                              |
// | Description : PS/2 keyboard frame receiver and scan-code set 2 decoder.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module ps2_key_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 24000
) (
  input  wire logic          clk_sys,
  input  wire logic          reset,
  ps2_key_decoder_if.slave   bus
);

  localparam int c_filt_w = $clog2(FILTER_LEN + 1);
  localparam int c_to_w   = $clog2(TIMEOUT + 1);
  localparam logic [c_filt_w-1:0] c_filt_last = c_filt_w'(FILTER_LEN - 1);
  localparam logic [c_filt_w-1:0] c_filt_one  = c_filt_w'(1);
  localparam logic [c_to_w-1:0]   c_to_last   = c_to_w'(TIMEOUT - 1);
  localparam logic [c_to_w-1:0]   c_to_one    = c_to_w'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic                r_filt, r_filt_d;
  logic [c_filt_w-1:0] r_filt_cnt;
  logic [c_to_w-1:0]   r_to_cnt;
  logic [2:0]          r_bit_cnt;
  logic [7:0]          r_shift;
  logic                r_par_ok;
  logic                r_ext, r_brk;
  logic [2:0]          r_skip;
  logic [10:0]         r_key;
  logic                r_err;

  logic                w_fall;
  logic                w_timeout;
  logic                w_frame_end;
  logic                w_frame_ok;
  logic                w_ext_nxt, w_brk_nxt, w_err_nxt;
  logic [2:0]          w_skip_nxt;
  logic [10:0]         w_key_nxt;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= bus.ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= bus.ps2_dat;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Filtered clock follows only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_filt     <= 1'b1;
      r_filt_d   <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_filt_d <= r_filt;
      if (r_clk_s2 != r_filt) begin
        if (r_filt_cnt == c_filt_last) begin
          r_filt     <= r_clk_s2;
          r_filt_cnt <= '0;
        end else begin
          r_filt_cnt <= r_filt_cnt + c_filt_one;
        end
      end else begin
        r_filt_cnt <= '0;
      end
    end
  end

  assign w_fall    = r_filt_d & ~r_filt;
  assign w_timeout = (r_state != IDLE) && !w_fall && (r_to_cnt == c_to_last);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (r_state == IDLE || w_fall) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + c_to_one;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_frame_end = 1'b0;
    if (w_timeout) begin
      w_state_nxt = IDLE;
    end else if (w_fall) begin
      case (r_state)
        IDLE:    if (!r_dat_s2) w_state_nxt = DATA;
        DATA:    if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
        PARITY:  w_state_nxt = STOP;
        STOP: begin
          w_state_nxt = IDLE;
          w_frame_end = 1'b1;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign w_frame_ok = w_frame_end & r_par_ok & r_dat_s2;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_par_ok  <= 1'b0;
    end else if (w_fall) begin
      case (r_state)
        IDLE:   r_bit_cnt <= 3'd0;
        DATA: begin
          r_shift   <= {r_dat_s2, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        PARITY: r_par_ok <= ^{r_dat_s2, r_shift};
        default: ;
      endcase
    end
  end

  // Byte interpretation happens on the stop-bit cycle so the key lands one cycle later.
  always_comb begin
    w_key_nxt  = r_key;
    w_ext_nxt  = r_ext;
    w_brk_nxt  = r_brk;
    w_skip_nxt = r_skip;
    w_err_nxt  = 1'b0;
    if (w_timeout || (w_frame_end && !w_frame_ok)) begin
      w_err_nxt  = 1'b1;
      w_ext_nxt  = 1'b0;
      w_brk_nxt  = 1'b0;
      w_skip_nxt = 3'd0;
    end else if (w_frame_ok) begin
      if (r_skip != 3'd0) begin
        w_skip_nxt = r_skip - 3'd1;
      end else begin
        case (r_shift)
          8'hE0: w_ext_nxt = 1'b1;
          8'hF0: w_brk_nxt = 1'b1;
          8'hE1: begin
            w_skip_nxt = 3'd7;
            w_ext_nxt  = 1'b0;
            w_brk_nxt  = 1'b0;
          end
          8'hFA, 8'hAA, 8'hEE, 8'hFE: begin
            w_ext_nxt = 1'b0;
            w_brk_nxt = 1'b0;
          end
          default: begin
            w_key_nxt = {~r_key[10], ~r_brk, r_ext, r_shift};
            w_ext_nxt = 1'b0;
            w_brk_nxt = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_key  <= 11'h000;
      r_ext  <= 1'b0;
      r_brk  <= 1'b0;
      r_skip <= 3'd0;
      r_err  <= 1'b0;
    end else begin
      r_key  <= w_key_nxt;
      r_ext  <= w_ext_nxt;
      r_brk  <= w_brk_nxt;
      r_skip <= w_skip_nxt;
      r_err  <= w_err_nxt;
    end
  end

  assign bus.ps2_key = r_key;
  assign bus.err     = r_err;

endmodule

`default_nettype wire
